// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: widths, opcodes, ALU operation codes and the
// ID/EX pipeline register layout.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int NREGS = 32;

  localparam logic [31:0] NOP = 32'h00000033;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            illegal;
  } idex_t;

  // alt selects SUB/SRA (instr[30]) where the funct3 has a second flavour
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file, two async read ports with write-first bypass, one sync write.
// x0 always reads 0; writes to it are dropped. Not reset.
module decode_stage_regfile
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (wen && waddr != 5'd0) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (wen && waddr == raddr1) ? wdata : mem[raddr1];
    if (raddr2 != 5'd0) rdata2 = (wen && waddr == raddr2) ? wdata : mem[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: operand read, immediate/control generation, registered into ID/EX.
// One-cycle latency; stalls (holds ID/EX) while execute withholds ex_ready.
module decode_stage
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  idex_t           dec, idex_q;
  logic            valid_q;

  assign opcode   = if_instr[6:0];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];
  assign rd_field = if_instr[11:7];

  decode_stage_regfile u_regfile (
    .clk    (clk),
    .raddr1 (if_instr[19:15]),
    .raddr2 (if_instr[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .wen    (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // Illegal encodings leave rd and all side-effect controls at their zero defaults
  always_comb begin
    dec         = '0;
    dec.pc      = if_pc;
    dec.rs1_val = rs1_data;
    dec.rs2_val = rs2_data;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.alu_op = alu_from_funct3(funct3, funct7[5]);
          dec.rd     = rd_field;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.imm     = imm_i;
        dec.alu_src = 1'b1;
        dec.alu_op  = alu_from_funct3(funct3, (funct3 == 3'b101) && if_instr[30]);
        dec.rd      = rd_field;
      end
      OPC_LOAD: begin
        dec.imm     = imm_i;
        dec.alu_src = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.rd      = rd_field;
      end
      OPC_STORE: begin
        dec.imm     = imm_s;
        dec.alu_src = 1'b1;
        dec.mem_wr  = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        dec.alu_op = {1'b0, funct3};
      end
      OPC_LUI: begin
        dec.imm     = imm_u;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_PASS_B;
        dec.rd      = rd_field;
      end
      OPC_AUIPC: begin
        dec.imm     = imm_u;
        dec.alu_src = 1'b1;
        dec.rd      = rd_field;
      end
      OPC_JAL: begin
        dec.imm     = imm_j;
        dec.alu_src = 1'b1;
        dec.jump    = 1'b1;
        dec.rd      = rd_field;
      end
      OPC_JALR: begin
        dec.imm     = imm_i;
        dec.alu_src = 1'b1;
        dec.jump    = 1'b1;
        dec.rd      = rd_field;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign id_ready = ex_ready | ~valid_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (id_ready) begin
      valid_q <= if_valid;
      if (if_valid) idex_q <= dec;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = idex_q.pc;
  assign ex_rs1_val = idex_q.rs1_val;
  assign ex_rs2_val = idex_q.rs2_val;
  assign ex_imm     = idex_q.imm;
  assign ex_rd      = idex_q.rd;
  assign ex_alu_op  = idex_q.alu_op;
  assign ex_alu_src = idex_q.alu_src;
  assign ex_mem_rd  = idex_q.mem_rd;
  assign ex_mem_wr  = idex_q.mem_wr;
  assign ex_branch  = idex_q.branch;
  assign ex_jump    = idex_q.jump;
  assign ex_illegal = idex_q.illegal;

endmodule
